// File: rtl/alu_cmd_pkg.sv
// Shared constants for the ALU command issuer: op codes, FSM encoding, div-by-zero result.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_cmd_pkg;

    // ALU select encoding
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_NAND = 3'd7;

    // Issuer FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Result reported for a divide with b == 0 (the bare ALU leaves this undefined)
    localparam logic [3:0] DIV0_RESULT = 4'hF;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO holding packed ALU commands.
// Latency: written entry is visible on rd_dat the cycle after push (first-word fall-through).
// Backpressure: push ignored while full, pop ignored while empty.
//
// Ports: clk, rst (sync, active-high); push/wr_dat write side; pop/rd_dat read side;
//        full/empty status derived from the extra pointer MSB.
module alu_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wr_dat;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Wraps a 4-bit combinational ALU: buffers commands, drives operands from registers, returns results.
// Latency: accept at edge N, operands driven after N+1, res_valid after N+2; one result per 2 cycles.
// Backpressure: cmd_ready = !fifo_full; result held stable in HOLD until res_ready.
//
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op command input;
//        alu_a/alu_b/alu_sel to the ALU, alu_y back from it;
//        res_valid/res_ready/res_data/res_op/res_err result output.
// Optional: define ALU_CMD_ISSUER_STATS_EN to add done_cnt/err_cnt saturating counters.
module alu_cmd_issuer
    import alu_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 4,
    parameter int OP_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op,
    output logic              res_err
`ifdef ALU_CMD_ISSUER_STATS_EN
    ,
    output logic [7:0]        done_cnt,
    output logic [7:0]        err_cnt
`endif
);

    localparam int CMD_W = 2*DATA_W + OP_W;

    logic [1:0]       state;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [CMD_W-1:0] fifo_rd_dat;
    logic             div0;
    logic             res_hs;

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign res_hs    = res_valid && res_ready;

    // Pop is only ever taken when the operand registers are free to load the entry.
    assign fifo_pop  = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_HOLD) && res_ready));

    assign div0 = (alu_sel == OP_W'(OP_DIV)) && (alu_b == '0);

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (fifo_push),
        .wr_dat ({cmd_a, cmd_b, cmd_op}),
        .pop    (fifo_pop),
        .rd_dat (fifo_rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {alu_a, alu_b, alu_sel} <= fifo_rd_dat;
                        state                   <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Operands have been stable for a full cycle; alu_y is settled.
                    res_valid <= 1'b1;
                    res_op    <= alu_sel;
                    if (div0) begin
                        res_data <= DATA_W'(DIV0_RESULT);
                        res_err  <= 1'b1;
                    end else begin
                        res_data <= alu_y;
                        res_err  <= 1'b0;
                    end
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (!fifo_empty) begin
                            {alu_a, alu_b, alu_sel} <= fifo_rd_dat;
                            state                   <= ST_DRIVE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_CMD_ISSUER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
            err_cnt  <= '0;
        end else if (res_hs) begin
            if (done_cnt != 8'hFF) done_cnt <= done_cnt + 8'd1;
            if (res_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_hs;
    assign unused_hs = res_hs;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: behavioural ALU, expected-result queue, randomized traffic.
// Latency: n/a.
// Backpressure: res_ready toggled randomly and held low in the full-FIFO scenario.
module tb_alu_cmd_issuer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [2:0] res_op;
    logic       res_err;
`ifdef ALU_CMD_ISSUER_STATS_EN
    logic [7:0] done_cnt;
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_cmd_issuer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_err   (res_err)
`ifdef ALU_CMD_ISSUER_STATS_EN
        ,
        .done_cnt  (done_cnt),
        .err_cnt   (err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in for the external combinational ALU; divide by zero returns junk on purpose.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_y = alu_a + alu_b;
            3'd1:    alu_y = alu_a - alu_b;
            3'd2:    alu_y = alu_a * alu_b;
            3'd3:    alu_y = (alu_b == 4'd0) ? 4'h0 : alu_a / alu_b;
            3'd4:    alu_y = alu_a & alu_b;
            3'd5:    alu_y = alu_a | alu_b;
            3'd6:    alu_y = alu_a ^ alu_b;
            default: alu_y = ~(alu_a & alu_b);
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {err, op, data} computed with integer arithmetic from the op definitions.
    function automatic logic [7:0] ref_result(input int a, input int b, input int op);
        int r;
        int e;
        e = 0;
        case (op)
            0: r = a + b;
            1: r = a - b + 16;
            2: r = a * b;
            3: if (b == 0) begin r = 15; e = 1; end else r = a / b;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = 15 - (a & b);
        endcase
        return {e[0], op[2:0], r[3:0]};
    endfunction

    logic [7:0] exp_q[$];
    int         cyc        = 0;
    bit         tput_chk   = 0;
    bit         tput_first = 1;
    int         tput_prev  = 0;
    int         done_m     = 0;
    int         err_m      = 0;

    // Scoreboard: every accepted command queues its expected result; any visible result must
    // match the head of the queue, and stays matched while it is held under backpressure.
    always @(negedge clk) begin
        logic [7:0] e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            done_m = 0;
            err_m  = 0;
        end else begin
`ifdef ALU_CMD_ISSUER_STATS_EN
            check("done_cnt", 32'(done_cnt), 32'(done_m));
            check("err_cnt", 32'(err_cnt), 32'(err_m));
`endif
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", 32'(1), 32'(0));
                end else begin
                    e = exp_q[0];
                    check("res_data", 32'(res_data), 32'(e[3:0]));
                    check("res_op", 32'(res_op), 32'(e[6:4]));
                    check("res_err", 32'(res_err), 32'(e[7]));
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        if (done_m < 255) done_m++;
                        if (e[7] && err_m < 255) err_m++;
                        if (tput_chk) begin
                            if (!tput_first) check("tput_gap", cyc - tput_prev, 2);
                            tput_first = 0;
                            tput_prev  = cyc;
                        end
                    end
                end
            end
            if (cmd_valid && cmd_ready)
                exp_q.push_back(ref_result(int'(cmd_a), int'(cmd_b), int'(cmd_op)));
        end
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        int t;
        bit done;
        t = 0;
        done = 0;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        while (!done && t < 100) begin
            done = cmd_ready;
            @(posedge clk); #1;
            t++;
        end
        cmd_valid = 1'b0;
        if (!done) check("send_timeout", 32'(1), 32'(0));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || res_valid) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 400) check("drain_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int acc;
        int cnt;
        int sent;
        int t;
        bit hs;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'(0));
        check("rst_res", 32'({res_data, res_op, res_err}), 32'(0));

        // Basic add with latency: accepted at edge N, valid after edge N+2
        res_ready = 1'b1;
        cmd_a = 4'd3; cmd_b = 4'd5; cmd_op = 3'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("lat_n", 32'(res_valid), 32'(0));
        @(posedge clk); #1;
        check("lat_n1", 32'(res_valid), 32'(0));
        @(posedge clk); #1;
        check("lat_n2", 32'(res_valid), 32'(1));
        check("add_data", 32'(res_data), 32'(8));
        wait_idle();

        // Wrap, subtract-wrap, divide by zero, then a good divide
        send(4'd9, 4'd8, 3'd0);
        send(4'd2, 4'd5, 3'd1);
        send(4'd7, 4'd0, 3'd3);
        wait_idle();
        send(4'd7, 4'd2, 3'd3);
        wait_idle();

        // Throughput: back-to-back commands drain one result every 2 cycles
        tput_first = 1;
        tput_chk = 1;
        for (int i = 0; i < 4; i++) send(4'(i + 1), 4'(i + 3), 3'd2);
        wait_idle();
        tput_chk = 0;

        // Full FIFO under backpressure: 6 offered back-to-back, 5 accepted
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_a = 4'(i + 4); cmd_b = 4'(i); cmd_op = 3'(i + 1); cmd_valid = 1'b1;
            if (cmd_ready) acc++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("full_accepted", 32'(acc), 32'(5));
        check("full_cmd_ready", 32'(cmd_ready), 32'(0));
        repeat (5) @(posedge clk);
        #1;
        check("full_hold_ready", 32'(cmd_ready), 32'(0));
        res_ready = 1'b1;
        wait_idle();

        // Reset while holding a result with two commands still buffered
        res_ready = 1'b0;
        send(4'd1, 4'd1, 3'd0);
        send(4'd2, 4'd2, 3'd5);
        send(4'd3, 4'd3, 3'd6);
        t = 0;
        while (!res_valid && t < 20) begin @(posedge clk); #1; t++; end
        check("pre_rst_valid", 32'(res_valid), 32'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_res_valid", 32'(res_valid), 32'(0));
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("mid_rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'(0));
        check("mid_rst_res", 32'({res_data, res_op, res_err}), 32'(0));
        res_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (res_valid) cnt++;
        end
        check("no_stale_results", 32'(cnt), 32'(0));

        // Randomized traffic: 300 commands, random valid gaps and res_ready
        sent = 0;
        t = 0;
        while ((sent < 300 || cmd_valid) && t < 20000) begin
            hs = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            t++;
            if (!cmd_valid || hs) begin
                if (sent < 300 && $urandom_range(9) < 7) begin
                    cmd_op = 3'($urandom_range(7));
                    cmd_a  = 4'($urandom_range(15));
                    cmd_b  = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
                    cmd_valid = 1'b1;
                    sent++;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            res_ready = ($urandom_range(9) < 6);
        end
        if (t >= 20000) check("random_timeout", 32'(0), 32'(1));
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Upstream/downstream wrapper stage for the 4-bit combinational ALU (ops: add, sub, mul, div, and, or, xor, nand).
- Accepts operation commands over a valid/ready handshake and buffers them in a 4-deep FIFO.
- Drives the ALU operand/select inputs from a register, captures the ALU result one cycle later, and presents it downstream over a second valid/ready handshake.
- Adds divide-by-zero detection; the bare ALU does not handle that case.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- DATA_W, 4, operand/result width; must match the ALU.
- OP_W, 3, operation select width; must match the ALU.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full.
- cmd_a  in  DATA_W  operand a.
- cmd_b  in  DATA_W  operand b.
- cmd_op  in  OP_W  operation code, same encoding as the ALU select.
- alu_a  out  DATA_W  registered operand a, to the ALU.
- alu_b  out  DATA_W  registered operand b, to the ALU.
- alu_sel  out  OP_W  registered select, to the ALU.
- alu_y  in  DATA_W  combinational ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_data  out  DATA_W  captured result.
- res_op  out  OP_W  op code that produced res_data.
- res_err  out  1  1 = divide by zero.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - FIFO emptied; state IDLE.
  - alu_a, alu_b, alu_sel, res_data and res_op = 0; res_valid = 0; res_err = 0.
  - cmd_ready is 1 from the first cycle after reset.
  - Reset wins over every concurrent event; an in-flight command or held result is discarded.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only from the FSM.
  - Simultaneous push and pop while full is not allowed: cmd_ready is already 0, so no push occurs.
  - Simultaneous push and pop while empty: the pushed entry is written; the pop is not taken because the FSM sees empty.
  - Pointers are log2(FIFO_DEPTH)+1 bits; they wrap naturally; full/empty come from MSB compare.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if FIFO not empty, pop the entry into alu_a/alu_b/alu_sel and go to DRIVE.
  - DRIVE: exactly one cycle, so the combinational ALU settles.
    - Capture: res_data <= alu_y, res_op <= alu_sel, res_err <= 0, res_valid <= 1; go to HOLD.
    - Divide-by-zero case (alu_sel == 3'b011 and alu_b == 0): res_data <= all ones (4'hF), res_err <= 1; alu_y is ignored.
  - HOLD: res_valid = 1; all result outputs stay stable until res_ready = 1.
    - On res_valid && res_ready, if FIFO not empty: pop the next entry into the operand registers, res_valid <= 0, go to DRIVE.
    - If FIFO empty: res_valid <= 0, go to IDLE.
- Latency: command accepted at edge N, popped at edge N+1, result valid after edge N+2 (3 cycles minimum).
- Throughput: one result per 2 cycles when downstream keeps res_ready = 1.
- Capacity: FIFO_DEPTH buffered commands plus 1 in DRIVE/HOLD.
- Arithmetic: the result is whatever the ALU returns, truncated to DATA_W (wraps mod 16; mul keeps the low 4 bits). The issuer does no arithmetic itself except the b==0 check.
- Stability: alu_a/alu_b/alu_sel hold their values in HOLD and IDLE.

Optional Feature:
- Macro: ALU_CMD_ISSUER_STATS_EN.
- With the macro, two extra output ports are added:
  - done_cnt, 8 bits: increments on every res_valid && res_ready.
  - err_cnt, 8 bits: increments on each handshaked result with res_err = 1.
  - Both saturate at 255 and clear on rst.
- Without the macro, the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package alu_cmd_pkg holds:
  - op-code localparams OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_NAND=7;
  - FSM state encoding (IDLE=0, DRIVE=1, HOLD=2);
  - DIV0_RESULT = all ones.
- One natural sub-module: alu_cmd_fifo, a generic sync FIFO with width DATA_W*2+OP_W and depth FIFO_DEPTH.

Test Plan:
- Basic add: cmd a=3, b=5, op=0, res_ready=1 → res_valid 3 cycles after accept, res_data=8, res_op=0, res_err=0.
- Wrap: a=9, b=8, op=0 → res_data=1. Then a=2, b=5, op=1 → res_data=4'hD.
- Divide by zero: a=7, b=0, op=3 → res_data=4'hF, res_err=1. Next command a=7, b=2, op=3 → res_data=3, res_err=0.
- Backpressure/full: res_ready=0, push 6 commands back-to-back → exactly 5 accepted, cmd_ready=0 thereafter, res_data stable. Then release res_ready → 5 results drain in order.
- Reset mid-operation: assert rst while in HOLD with 2 FIFO entries → next cycle res_valid=0, cmd_ready=1, all outputs 0, no stale results afterwards.
- Stats (macro on): 4 ops including 1 divide-by-zero → done_cnt=4, err_cnt=1. Then 300 ops → done_cnt saturates at 255.
